datapath2: RTL and testbench
============================

# datapath2

Single-bus 32-bit RISC datapath for the phase-2 CPU. It holds the register file, PC, IR, MAR, MDR, Y, Z, ALU, select-and-encode logic, the branch condition (CON) flip-flop, an output port and 512-word memory. An external control sequencer (or testbench) drives every control signal one step at a time. The block has no instruction sequencing of its own.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-low; clears all registers.
- PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout  in  1 each  bus-driver selects (PC, Z, MDR, manualBusInput, selected register, selected register with R0 forced to zero, sign-extended constant).
- PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn  in  1 each  register load enables.
- Read  in  1  MDR input mux selects memory data instead of bus.
- Write  in  1  memory write strobe.
- OpCode  in  5  ALU operation select.
- manualBusInput  in  32  externally supplied bus value.
- Gra, Grb, Grc  in  1 each  register-field select for Rin/Rout/BAout.
- ConOtp  out  1  CON flip-flop value.
- OutportData  out  32  output port register.

## Operation
- **Bus**
  - Combinational OR of all enabled sources; 0 when none is enabled.
  - Control must keep sources one-hot; multiple drivers OR together.
- **IR fields**
  - op = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - C = IR[18:0], sign-extended from bit 18.
  - C2 = IR[20:19].
- **Select/encode**
  - Index = Ra if Gra, else Rb if Grb, else Rc if Grc, else 0.
  - Rin loads R[index] from the bus.
  - Rout drives R[index].
  - BAout drives R[index], or 0 when index = 0.
- **Register file**: R0–R15, 32 bits each. R0 is writable and readable via Rout.
- **ALU**
  - A = Y, B = bus, result to Z on Zin.
  - OpCode: 0 pass B, 1 A−B, 2 A+B, 3 A&B, 4 A|B, 5 A>>B[4:0] logical, 6 arithmetic shift right, 7 shift left, 8 rotate right, 9 rotate left, 12 B+1, 13 −B, 14 ~B.
  - Any other OpCode gives Z = 0.
  - Arithmetic is modulo 2^32; no flags.
- **MDR**: on MDRin, loads mem[MAR[8:0]] if Read, else the bus.
- **Memory**
  - 512×32, asynchronous read at MAR[8:0].
  - On a clock edge with Write=1: mem[MAR[8:0]] ← MDR (MDR value before the edge).
  - Not cleared by reset; initial content undefined.
- **CON**
  - On CONin, CON ← condition of the bus value per C2: 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
  - ConOtp = CON.
- **Outport**: OutportData ← bus on OutportIn.

## Timing
- Every enabled register loads on the rising clk edge at the end of the cycle in which its enable is high.
- The bus, ALU and select logic are combinational, so a source and its destination are asserted in the same cycle.
- One control step takes exactly one cycle.
- While clr = 0 (asynchronous), the following hold 0 and ignore enables: PC, IR, MAR, MDR, Y, Z, R0–R15, CON, Outport.
  - Consequently ConOtp = 0 and OutportData = 0.
- Reset may occur mid-sequence: state is lost and resumes from 0 after clr returns high. Memory is untouched.
- Write and MDRin in the same cycle: memory gets the old MDR, MDR gets the new value.
- A register that is both bus source and destination in one cycle loads its own value (no combinational loop).

## Test plan
- **Reset**: hold clr=0 for 2 cycles after loading nonzero values → all registers read 0, ConOtp=0, OutportData=0.
- **Memory**
  - Step 1: manualBusInput=74, MBIout+MARin → MAR=74.
  - Step 2: manualBusInput=9, MBIout+MDRin → MDR=9.
  - Step 3: Write → mem[74]=9.
  - Step 4: clear MDR, then Read+MDRin → MDR=9.
- **Fetch**
  - Start: PC=0, mem[0]=0x9B000019.
  - PCout+MARin+OpCode=12+Zin → MAR=0, Z=1.
  - Zlowout+PCin → PC=1.
  - Read+MDRin → MDR=0x9B000019.
  - MDRout+IRin → IR=0x9B000019.
- **Branch condition** (IR=0x9B000019, Ra=R6, C2=00)
  - R6=0: Gra+Rout+CONin → ConOtp=1.
  - R6=5: Gra+Rout+CONin → ConOtp=0.
  - IR with C2=11 and R6=0x80000000 → ConOtp=1.
- **Branch target** (PC=1)
  - PCout+Yin, then Cout+OpCode=2+Zin → Z=0x1A.
  - Zlowout+PCin → PC=26.
  - IR[18:0]=0x7FFFF with Cout → bus=0xFFFFFFFF.
- **R0/BAout and ALU**
  - R0=0x55, Rb=0: Grb+BAout → bus=0; Grb+Rout → bus=0x55.
  - Y=0xF0000000, bus=4, OpCode 6 → Z=0xFF000000.
  - Y=0xF0000000, bus=4, OpCode 8 → Z=0x0F000000.

Source files
------------

// File: rtl/datapath2_if.sv
// datapath2_if: control/status bundle between the control sequencer and the
// single-bus datapath.
//   master (sequencer / bench): drives bus-driver selects, load enables,
//     memory strobes, ALU opcode, manual bus value and register-field selects;
//     observes ConOtp and OutportData.
//   slave (datapath2): the mirror image.
interface datapath2_if;
  // bus-driver selects
  logic        PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout;
  // register load enables
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn;
  // memory
  logic        Read, Write;
  // ALU and manual bus value
  logic [4:0]  OpCode;
  logic [31:0] manualBusInput;
  // register-field selects
  logic        Gra, Grb, Grc;
  // status
  logic        ConOtp;
  logic [31:0] OutportData;

  modport master (
    output PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn,
    output Read, Write, OpCode, manualBusInput, Gra, Grb, Grc,
    input  ConOtp, OutportData
  );

  modport slave (
    input  PCout, Zlowout, MDRout, MBIout, Rout, BAout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn,
    input  Read, Write, OpCode, manualBusInput, Gra, Grb, Grc,
    output ConOtp, OutportData
  );
endinterface

// File: rtl/datapath2.sv
// datapath2: single-bus 32-bit RISC datapath (register file, PC, IR, MAR,
// MDR, Y, Z, ALU, select/encode, CON flip-flop, output port, 512x32 memory).
// Every control signal comes from an external sequencer, one step per cycle.
//   clk  : system clock, rising edge
//   clr  : asynchronous active-low clear of all registers (not memory)
//   dp   : datapath2_if.slave -- controls in, ConOtp / OutportData out
module datapath2 (
  input  logic          clk,
  input  logic          clr,
  datapath2_if.slave    dp
);

  logic [31:0]       pc_q, ir_q, mdr_q, y_q, z_q, out_q;
  logic [8:0]        mar_q;   // only the memory address bits are kept
  logic              con_q;
  logic [15:0][31:0] rf_q;
  logic [31:0]       mem [512];

  logic [31:0] bus;
  logic [31:0] alu;
  logic [31:0] c_sext;
  logic [31:0] mem_rd;
  logic [3:0]  sel_idx;
  logic        cond;

  // opcode field is decoded by the external sequencer, not here
  logic unused_op;
  assign unused_op = ^ir_q[31:27];

  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
  assign mem_rd = mem[mar_q];

  // select/encode: priority Ra > Rb > Rc, default R0
  always_comb begin
    sel_idx = 4'd0;
    if      (dp.Gra) sel_idx = ir_q[26:23];
    else if (dp.Grb) sel_idx = ir_q[22:19];
    else if (dp.Grc) sel_idx = ir_q[18:15];
  end

  // bus: wired-OR of every enabled source
  always_comb begin
    bus = '0;
    if (dp.PCout)   bus = bus | pc_q;
    if (dp.Zlowout) bus = bus | z_q;
    if (dp.MDRout)  bus = bus | mdr_q;
    if (dp.MBIout)  bus = bus | dp.manualBusInput;
    if (dp.Rout)    bus = bus | rf_q[sel_idx];
    if (dp.BAout && sel_idx != 4'd0) bus = bus | rf_q[sel_idx];
    if (dp.Cout)    bus = bus | c_sext;
  end

  // ALU: A = Y, B = bus
  logic [4:0] sh;
  logic [5:0] sh_inv;
  assign sh     = bus[4:0];
  assign sh_inv = 6'd32 - {1'b0, sh};   // shift by 32 yields 0, so sh=0 rotates cleanly

  always_comb begin
    alu = '0;
    unique case (dp.OpCode)
      5'd0:    alu = bus;
      5'd1:    alu = y_q - bus;
      5'd2:    alu = y_q + bus;
      5'd3:    alu = y_q & bus;
      5'd4:    alu = y_q | bus;
      5'd5:    alu = y_q >> sh;
      5'd6:    alu = $unsigned($signed(y_q) >>> sh);
      5'd7:    alu = y_q << sh;
      5'd8:    alu = (y_q >> sh) | (y_q << sh_inv);
      5'd9:    alu = (y_q << sh) | (y_q >> sh_inv);
      5'd12:   alu = bus + 32'd1;
      5'd13:   alu = 32'd0 - bus;
      5'd14:   alu = ~bus;
      default: alu = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    unique case (ir_q[20:19])
      2'b00: cond = (bus == 32'd0);
      2'b01: cond = (bus != 32'd0);
      2'b10: cond = ~bus[31];
      2'b11: cond = bus[31];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      out_q <= '0;
      con_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      if (dp.PCin)      pc_q  <= bus;
      if (dp.IRin)      ir_q  <= bus;
      if (dp.MARin)     mar_q <= bus[8:0];
      if (dp.MDRin)     mdr_q <= dp.Read ? mem_rd : bus;
      if (dp.Yin)       y_q   <= bus;
      if (dp.Zin)       z_q   <= alu;
      if (dp.OutportIn) out_q <= bus;
      if (dp.CONin)     con_q <= cond;
      if (dp.Rin)       rf_q[sel_idx] <= bus;
    end
  end

  // memory is not reset; a write takes the MDR value from before the edge
  always_ff @(posedge clk) begin
    if (dp.Write) mem[mar_q] <= mdr_q;
  end

  assign dp.ConOtp      = con_q;
  assign dp.OutportData = out_q;

endmodule

// File: tb/tb_datapath2.sv
module tb_datapath2;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  datapath2_if dif ();
  datapath2 dut (.clk(clk), .clr(clr), .dp(dif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {dif.PCout, dif.Zlowout, dif.MDRout, dif.MBIout, dif.Rout, dif.BAout, dif.Cout} = '0;
    {dif.PCin, dif.IRin, dif.MARin, dif.MDRin, dif.Yin, dif.Zin, dif.Rin, dif.CONin, dif.OutportIn} = '0;
    {dif.Read, dif.Write, dif.Gra, dif.Grb, dif.Grc} = '0;
    dif.OpCode = 5'd0;
    dif.manualBusInput = '0;
  endtask

  // one control step: controls are already set, clock them, then drop them
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic mbi(input logic [31:0] v);
    dif.MBIout = 1'b1; dif.manualBusInput = v;
  endtask

  task automatic show_z(input string tag, input logic [31:0] exp);
    dif.Zlowout = 1'b1; dif.OutportIn = 1'b1; tick();
    chk(tag, dif.OutportData, exp);
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [31:0] exp);
    mbi(a); dif.Yin = 1'b1; tick();
    mbi(b); dif.OpCode = op; dif.Zin = 1'b1; tick();
    show_z(tag, exp);
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    clr = 1'b1;

    // ---- reset: load nonzero state, then hold clr low
    dif.CONin = 1'b1; tick();                        // IR=0, C2=00, bus=0 -> CON=1
    mbi(32'h1234);
    {dif.PCin, dif.IRin, dif.MARin, dif.MDRin, dif.Yin, dif.Zin, dif.Rin, dif.OutportIn} = '1;
    tick();
    chk("pre_con", {31'd0, dif.ConOtp}, 32'd1);
    chk("pre_out", dif.OutportData, 32'h1234);
    chk("pre_r0",  dut.rf_q[0], 32'h1234);
    clr = 1'b0; #1;
    chk("rst_async_out", dif.OutportData, 32'd0);
    mbi(32'hFFFF); dif.PCin = 1'b1; dif.Rin = 1'b1;   // enables ignored while clear
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc",  dut.pc_q, 0);
    chk("rst_ir",  dut.ir_q, 0);
    chk("rst_mar", {23'd0, dut.mar_q}, 0);
    chk("rst_mdr", dut.mdr_q, 0);
    chk("rst_y",   dut.y_q, 0);
    chk("rst_z",   dut.z_q, 0);
    chk("rst_r0",  dut.rf_q[0], 0);
    chk("rst_con", {31'd0, dif.ConOtp}, 0);
    chk("rst_out", dif.OutportData, 0);
    idle();
    clr = 1'b1;

    // ---- memory
    mbi(32'd74); dif.MARin = 1'b1; tick();
    chk("mem_mar", {23'd0, dut.mar_q}, 32'd74);
    mbi(32'd9);  dif.MDRin = 1'b1; tick();
    chk("mem_mdr", dut.mdr_q, 32'd9);
    dif.Write = 1'b1; tick();
    mbi(32'd0);  dif.MDRin = 1'b1; tick();
    dif.Read = 1'b1; dif.MDRin = 1'b1; tick();
    dif.MDRout = 1'b1; dif.OutportIn = 1'b1; tick();
    chk("mem_rd74", dif.OutportData, 32'd9);
    // Write with MDRin: memory gets the old MDR (9)
    mbi(32'h77); dif.MDRin = 1'b1; dif.Write = 1'b1; tick();
    chk("wr_mdr_new", dut.mdr_q, 32'h77);
    dif.Read = 1'b1; dif.MDRin = 1'b1; tick();
    chk("wr_mem_old", dut.mdr_q, 32'd9);

    // ---- fetch (PC=0 since reset)
    mbi(32'd0); dif.MARin = 1'b1; tick();
    mbi(32'h9B000019); dif.MDRin = 1'b1; tick();
    dif.Write = 1'b1; tick();
    mbi(32'd5); dif.MARin = 1'b1; tick();            // move MAR away so the fetch sets it
    dif.PCout = 1'b1; dif.MARin = 1'b1; dif.OpCode = 5'd12; dif.Zin = 1'b1; tick();
    chk("f_mar", {23'd0, dut.mar_q}, 32'd0);
    chk("f_z",   dut.z_q, 32'd1);
    dif.Zlowout = 1'b1; dif.PCin = 1'b1; tick();
    chk("f_pc",  dut.pc_q, 32'd1);
    dif.Read = 1'b1; dif.MDRin = 1'b1; tick();
    chk("f_mdr", dut.mdr_q, 32'h9B000019);
    dif.MDRout = 1'b1; dif.IRin = 1'b1; tick();
    chk("f_ir",  dut.ir_q, 32'h9B000019);

    // ---- branch condition, Ra = R6
    dif.Gra = 1'b1; dif.Rout = 1'b1; dif.CONin = 1'b1; tick();
    chk("con_eq0", {31'd0, dif.ConOtp}, 32'd1);
    mbi(32'd5); dif.Gra = 1'b1; dif.Rin = 1'b1; tick();
    dif.Gra = 1'b1; dif.Rout = 1'b1; dif.CONin = 1'b1; tick();
    chk("con_eq0_5", {31'd0, dif.ConOtp}, 32'd0);
    mbi(32'h9B180019); dif.IRin = 1'b1; tick();
    dif.Gra = 1'b1; dif.Rout = 1'b1; dif.CONin = 1'b1; tick();
    chk("con_neg_5", {31'd0, dif.ConOtp}, 32'd0);
    mbi(32'h80000000); dif.Gra = 1'b1; dif.Rin = 1'b1; tick();
    dif.Gra = 1'b1; dif.Rout = 1'b1; dif.CONin = 1'b1; tick();
    chk("con_neg", {31'd0, dif.ConOtp}, 32'd1);

    // ---- branch target
    mbi(32'h9B000019); dif.IRin = 1'b1; tick();
    dif.PCout = 1'b1; dif.Yin = 1'b1; tick();
    dif.Cout = 1'b1; dif.OpCode = 5'd2; dif.Zin = 1'b1; tick();
    chk("bt_z", dut.z_q, 32'h1A);
    dif.Zlowout = 1'b1; dif.PCin = 1'b1; tick();
    chk("bt_pc", dut.pc_q, 32'd26);
    mbi(32'h0007FFFF); dif.IRin = 1'b1; tick();
    dif.Cout = 1'b1; #1;
    chk("c_sext_bus", dut.bus, 32'hFFFFFFFF);
    dif.OutportIn = 1'b1; tick();
    chk("c_sext_out", dif.OutportData, 32'hFFFFFFFF);

    // ---- R0 / BAout (IR Rb field = 0)
    mbi(32'h55); dif.Rin = 1'b1; tick();
    dif.Grb = 1'b1; dif.BAout = 1'b1; dif.OutportIn = 1'b1; tick();
    chk("ba_r0", dif.OutportData, 32'd0);
    dif.Grb = 1'b1; dif.Rout = 1'b1; dif.OutportIn = 1'b1; tick();
    chk("rout_r0", dif.OutportData, 32'h55);

    // ---- ALU
    alu_op(5'd6,  32'hF0000000, 32'd4, "alu_asr",  32'hFF000000);
    alu_op(5'd8,  32'hF0000000, 32'd4, "alu_ror",  32'h0F000000);
    alu_op(5'd9,  32'hF0000001, 32'd4, "alu_rol",  32'h0000001F);
    alu_op(5'd5,  32'hF0000000, 32'd4, "alu_lsr",  32'h0F000000);
    alu_op(5'd7,  32'h0000000F, 32'd28, "alu_shl", 32'hF0000000);
    alu_op(5'd1,  32'h00000003, 32'd4, "alu_sub",  32'hFFFFFFFF);
    alu_op(5'd3,  32'hF0F0F0F0, 32'h0FF00FF0, "alu_and", 32'h00F000F0);
    alu_op(5'd4,  32'hF0F0F0F0, 32'h0FF00FF0, "alu_or",  32'hFFF0FFF0);
    alu_op(5'd13, 32'd0, 32'd4, "alu_neg",  32'hFFFFFFFC);
    alu_op(5'd14, 32'd0, 32'h0000FFFF, "alu_not", 32'hFFFF0000);
    alu_op(5'd8,  32'h12345678, 32'd0, "alu_ror0", 32'h12345678);
    alu_op(5'd10, 32'h12345678, 32'd1, "alu_bad",  32'd0);

    // ---- mid-sequence reset leaves memory intact
    clr = 1'b0; #3; clr = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out", dif.OutportData, 32'd0);
    mbi(32'd74); dif.MARin = 1'b1; tick();
    dif.Read = 1'b1; dif.MDRin = 1'b1; tick();
    chk("rst2_mem", dut.mdr_q, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
